bcd_mod_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter with programmable modulus, parallel load with validity checking, and carry/borrow outputs for cascading. It is the generic counting element of the digital clock. One instance per field: seconds and minutes use MODULUS=60, hours use MODULUS=24, and a single decade uses DIGITS=1, MODULUS=10. Chaining is done through the terminal-count output into the next stage's En.

---
 rtl/bcd_mod_counter.sv | 78 +++++++
 tb/tb_bcd_mod_counter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: multi-digit BCD up/down counter with programmable modulus, checked load and cascade carry.
module bcd_mod_counter #(
    parameter int DIGITS = 2,
    parameter int MODULUS = 60
) (
    input  logic                CP,
    input  logic                nCLR,
    input  logic                Load,
    input  logic                En,
    input  logic                dir,
    input  logic [4*DIGITS-1:0] D,
    output logic [4*DIGITS-1:0] Q,
    output logic                TC,
    output logic                Wrap,
    output logic                LdErr
);
    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX = to_bcd(MODULUS - 1);

    logic [W-1:0] inc;
    logic [W-1:0] dec;
    logic         ci;
    logic         bo;
    logic         nib_ok;
    logic         at_end;
    logic         ok;

    // Ripple carry/borrow across digits; each digit rolls 9->0 or 0->9 on its own.
    always_comb begin
        inc = Q;
        dec = Q;
        ci = 1'b1;
        bo = 1'b1;
        nib_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            inc[4*i +: 4] = ci ? ((Q[4*i +: 4] == 4'd9) ? 4'd0 : Q[4*i +: 4] + 4'd1) : Q[4*i +: 4];
            dec[4*i +: 4] = bo ? ((Q[4*i +: 4] == 4'd0) ? 4'd9 : Q[4*i +: 4] - 4'd1) : Q[4*i +: 4];
            ci = ci & (Q[4*i +: 4] == 4'd9);
            bo = bo & (Q[4*i +: 4] == 4'd0);
            nib_ok = nib_ok & (D[4*i +: 4] <= 4'd9);
        end
    end

    // With all nibbles valid, packed BCD orders the same as its decimal value.
    assign ok     = nib_ok && (D <= MAX);
    assign at_end = dir ? (Q == MAX) : (Q == '0);
    assign TC     = En & ~Load & nCLR & at_end;

    always_ff @(posedge CP) begin
        if (!nCLR) begin
            Q     <= '0;
            Wrap  <= 1'b0;
            LdErr <= 1'b0;
        end else if (Load) begin
            Wrap  <= 1'b0;
            LdErr <= !ok;
            if (ok) Q <= D;
        end else if (En) begin
            Wrap <= at_end;
            Q    <= dir ? (at_end ? '0 : inc) : (at_end ? MAX : dec);
        end else begin
            Wrap <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: seconds/minutes cascade plus an hours stage, checked every cycle against an integer model.
module tb_bcd_mod_counter;
    logic       clk = 1'b0;
    logic       nclr;
    logic       load[3];
    logic       en[3];
    logic       dir[3];
    logic [7:0] d[3];
    logic [7:0] q[3];
    logic       tc[3];
    logic       wr[3];
    logic       le[3];

    int  mods[3] = '{60, 60, 24};
    int  mv[3];
    bit  mw[3];
    bit  me[3];
    bit  chk = 1'b0;
    int  tests = 0;
    int  fails = 0;

    always #5 clk = ~clk;

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_sec (
        .CP(clk), .nCLR(nclr), .Load(load[0]), .En(en[0]), .dir(dir[0]), .D(d[0]),
        .Q(q[0]), .TC(tc[0]), .Wrap(wr[0]), .LdErr(le[0])
    );
    bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_min (
        .CP(clk), .nCLR(nclr), .Load(load[1]), .En(tc[0]), .dir(dir[1]), .D(d[1]),
        .Q(q[1]), .TC(tc[1]), .Wrap(wr[1]), .LdErr(le[1])
    );
    bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_hr (
        .CP(clk), .nCLR(nclr), .Load(load[2]), .En(en[2]), .dir(dir[2]), .D(d[2]),
        .Q(q[2]), .TC(tc[2]), .Wrap(wr[2]), .LdErr(le[2])
    );

    function automatic logic [7:0] bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int dval(logic [7:0] b);
        if (b[3:0] > 4'd9 || b[7:4] > 4'd9) return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit tc_of(int v, int m, bit e, bit l, bit dr);
        return e & ~l & nclr & (dr ? v == m - 1 : v == 0);
    endfunction

    function automatic bit model_tc(int k);
        bit e;
        e = (k == 1) ? tc_of(mv[0], mods[0], en[0], load[0], dir[0]) : en[k];
        return tc_of(mv[k], mods[k], e, load[k], dir[k]);
    endfunction

    always @(posedge clk)
        for (int k = 0; k < 3; k++) begin
            if (!nclr) begin
                mv[k] <= 0;
                mw[k] <= 1'b0;
                me[k] <= 1'b0;
            end else if (load[k]) begin
                mw[k] <= 1'b0;
                if (dval(d[k]) >= 0 && dval(d[k]) < mods[k]) begin
                    mv[k] <= dval(d[k]);
                    me[k] <= 1'b0;
                end else me[k] <= 1'b1;
            end else if (k == 1 ? model_tc(0) : en[k]) begin
                mw[k] <= dir[k] ? mv[k] == mods[k] - 1 : mv[k] == 0;
                mv[k] <= dir[k] ? (mv[k] + 1) % mods[k] : (mv[k] + mods[k] - 1) % mods[k];
            end else mw[k] <= 1'b0;
        end

    task automatic check(string nm, int k, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (chk)
            for (int k = 0; k < 3; k++) begin
                check("Q", k, int'(q[k]), int'(bcd(mv[k])));
                check("TC", k, int'(tc[k]), int'(model_tc(k)));
                check("Wrap", k, int'(wr[k]), int'(mw[k]));
                check("LdErr", k, int'(le[k]), int'(me[k]));
            end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        nclr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load[k] = 1'b0;
            en[k] = 1'b0;
            dir[k] = 1'b1;
            d[k] = 8'h00;
        end
        en[0] = 1'b1;
        cyc(1);
        chk = 1'b1;
        cyc(1);
        check("rst_q", 0, int'(q[0]), 8'h00);
        check("rst_tc", 0, int'(tc[0]), 0);
        check("rst_wrap", 0, int'(wr[0]), 0);
        check("rst_lderr", 0, int'(le[0]), 0);
        nclr = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            cyc(1);
            if (i == 9) check("up_09", 0, int'(q[0]), 8'h09);
            if (i == 10) check("up_10", 0, int'(q[0]), 8'h10);
            if (i == 59) begin
                check("up_59", 0, int'(q[0]), 8'h59);
                check("up_tc59", 0, int'(tc[0]), 1);
                check("up_nowrap", 0, int'(wr[0]), 0);
            end
            if (i == 60) begin
                check("up_00", 0, int'(q[0]), 8'h00);
                check("up_wrap", 0, int'(wr[0]), 1);
                check("up_min", 1, int'(q[1]), 8'h01);
            end
        end
        en[0] = 1'b0;
        load[0] = 1'b1;
        d[0] = 8'h01;
        cyc(1);
        check("dn_01", 0, int'(q[0]), 8'h01);
        load[0] = 1'b0;
        en[0] = 1'b1;
        dir[0] = 1'b0;
        dir[1] = 1'b0;
        cyc(1);
        check("dn_00", 0, int'(q[0]), 8'h00);
        check("dn_tc", 0, int'(tc[0]), 1);
        cyc(1);
        check("dn_59", 0, int'(q[0]), 8'h59);
        check("dn_wrap", 0, int'(wr[0]), 1);
        cyc(1);
        check("dn_58", 0, int'(q[0]), 8'h58);
        check("dn_wrap_end", 0, int'(wr[0]), 0);
        en[0] = 1'b0;
        load[0] = 1'b1;
        d[0] = 8'h45;
        cyc(1);
        check("ld_45", 0, int'(q[0]), 8'h45);
        check("ld_45_err", 0, int'(le[0]), 0);
        d[0] = 8'h4A;
        cyc(1);
        check("ld_4a", 0, int'(q[0]), 8'h45);
        check("ld_4a_err", 0, int'(le[0]), 1);
        d[0] = 8'h60;
        cyc(1);
        check("ld_60", 0, int'(q[0]), 8'h45);
        check("ld_60_err", 0, int'(le[0]), 1);
        d[0] = 8'h00;
        cyc(1);
        check("ld_00", 0, int'(q[0]), 8'h00);
        check("ld_00_err", 0, int'(le[0]), 0);
        check("ld_00_wrap", 0, int'(wr[0]), 0);
        d[0] = 8'h23;
        cyc(1);
        nclr = 1'b0;
        d[0] = 8'h11;
        en[0] = 1'b1;
        cyc(1);
        check("prio_clr", 0, int'(q[0]), 8'h00);
        nclr = 1'b1;
        load[0] = 1'b0;
        en[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("hold_q", 0, int'(q[0]), 8'h00);
            check("hold_tc", 0, int'(tc[0]), 0);
        end
        load[2] = 1'b1;
        d[2] = 8'h19;
        cyc(1);
        check("hr_19", 2, int'(q[2]), 8'h19);
        load[2] = 1'b0;
        en[2] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            check("hr_seq", 2, int'(q[2]), int'(bcd((19 + i) % 24)));
        end
        check("hr_wrap", 2, int'(wr[2]), 1);
        en[2] = 1'b0;
        load[2] = 1'b1;
        d[2] = 8'h24;
        cyc(1);
        check("hr_24_err", 2, int'(le[2]), 1);
        check("hr_24_q", 2, int'(q[2]), 8'h00);
        load[2] = 1'b0;
        load[0] = 1'b1;
        d[0] = 8'h58;
        load[1] = 1'b1;
        d[1] = 8'h00;
        dir[0] = 1'b1;
        dir[1] = 1'b1;
        cyc(1);
        load[0] = 1'b0;
        load[1] = 1'b0;
        en[0] = 1'b1;
        cyc(1);
        check("cas_sec59", 0, int'(q[0]), 8'h59);
        check("cas_min00", 1, int'(q[1]), 8'h00);
        check("cas_tc", 0, int'(tc[0]), 1);
        cyc(1);
        check("cas_sec00", 0, int'(q[0]), 8'h00);
        check("cas_min01", 1, int'(q[1]), 8'h01);
        dir[0] = 1'b0;
        dir[1] = 1'b0;
        cyc(1);
        check("rev_sec59", 0, int'(q[0]), 8'h59);
        check("rev_min00", 1, int'(q[1]), 8'h00);
        for (int i = 0; i < 400; i++) begin
            nclr = $urandom_range(0, 31) != 0;
            for (int k = 0; k < 3; k++) begin
                load[k] = $urandom_range(0, 7) == 0;
                en[k] = $urandom_range(0, 3) != 0;
                dir[k] = $urandom_range(0, 1) == 1;
                d[k] = $urandom_range(0, 1) == 1 ? bcd($urandom_range(0, mods[k] - 1)) : 8'($urandom);
            end
            cyc(1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
